// File: rtl/rtc_segscan_decoder.sv
// Receive side of the multiplexed 7-segment scan: decodes strobed
// digits back to BCD and delivers 6-digit frames over valid/ready.
// Ports:
//   i_sclk, i_reset_n        clock, async active-low reset
//   i_segments[7:0]          active-low {dp,g,f,e,d,c,b,a}, dp ignored
//   i_digits[7:0]            active-low digit enables, bit0 rightmost
//   o_count[23:0]            decoded frame, digit k in [4k+3:4k]
//   o_valid / i_ready        frame handshake
//   o_err                    frame held an undecodable pattern
//   o_overrun                pulse: completed frame dropped (slot busy)
//   o_stale                  timeout seen, cleared by next capture
module rtc_segscan_decoder #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        i_sclk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_segments,
    input  logic [7:0]  i_digits,
    output logic [23:0] o_count,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_err,
    output logic        o_overrun,
    output logic        o_stale
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

    logic          unused_dp;
    logic [6:0]    seg_s1_q, seg_s2_q, prev_seg_q;
    logic [7:0]    dig_s1_q, dig_s2_q, prev_dig_q;
    logic [SW-1:0] settle_q, settle_d;
    logic          took_q, took_d;
    logic [5:0]    bitmap_q, bitmap_d;
    logic [23:0]   shadow_q, shadow_d;
    logic          ferr_q, ferr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [23:0]   count_q, count_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          overrun_q, overrun_d;
    logic          stale_q, stale_d;

    logic [5:0]    sel_n;
    logic          legal, same, capture, bad, complete, timeout, accept;
    logic [2:0]    idx;
    logic [3:0]    nib;

    assign unused_dp = i_segments[7];

    // Strobe qualification and settle counting
    always_comb begin
        sel_n = ~dig_s2_q[5:0];
        legal = (&dig_s2_q[7:6]) && (sel_n != 6'd0)
                && ((sel_n & (sel_n - 6'd1)) == 6'd0);
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (sel_n[i]) idx = 3'(i);
        end
        same = (dig_s2_q == prev_dig_q) && (seg_s2_q == prev_seg_q);
        settle_d = settle_q;
        took_d   = took_q;
        if (!legal) begin
            settle_d = '0;
            took_d   = 1'b0;
        end else if (!same) begin
            settle_d = SW'(1);
            took_d   = 1'b0;
        end else if (settle_q != SMAX) begin
            settle_d = settle_q + SW'(1);
        end
        // A strobe is captured once; a change re-arms it.
        capture = legal && (settle_d == SMAX) && !took_d;
        if (capture) took_d = 1'b1;
    end

    always_comb begin
        bad = 1'b0;
        unique case (seg_s2_q)
            7'h40: nib = 4'd0;
            7'h79: nib = 4'd1;
            7'h24: nib = 4'd2;
            7'h30: nib = 4'd3;
            7'h19: nib = 4'd4;
            7'h12: nib = 4'd5;
            7'h02: nib = 4'd6;
            7'h78: nib = 4'd7;
            7'h00: nib = 4'd8;
            7'h10: nib = 4'd9;
            default: begin
                nib = 4'hF;
                bad = 1'b1;
            end
        endcase
    end

    // Frame assembly, timeout and output slot
    always_comb begin
        tmo_d = capture ? '0
              : (tmo_q == TMAX) ? tmo_q : tmo_q + TW'(1);
        timeout  = (tmo_d == TMAX) && (tmo_q != TMAX);
        complete = (bitmap_q == 6'h3F);
        bitmap_d = (complete || timeout) ? 6'd0 : bitmap_q;
        ferr_d   = (complete || timeout) ? 1'b0 : ferr_q;
        shadow_d = shadow_q;
        if (capture) begin
            bitmap_d[idx] = 1'b1;
            shadow_d[{idx, 2'b00} +: 4] = nib;
            if (bad) ferr_d = 1'b1;
        end
        accept    = valid_q && i_ready;
        count_d   = count_q;
        err_d     = err_q;
        valid_d   = valid_q && !accept;
        overrun_d = 1'b0;
        if (complete) begin
            if (!valid_q || accept) begin
                count_d = shadow_q;
                err_d   = ferr_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        stale_d = stale_q;
        if (timeout) stale_d = 1'b1;
        if (capture) stale_d = 1'b0;
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            prev_seg_q <= '0;
            dig_s1_q   <= '0;
            dig_s2_q   <= '0;
            prev_dig_q <= '0;
            settle_q   <= '0;
            took_q     <= 1'b0;
            bitmap_q   <= '0;
            shadow_q   <= '0;
            ferr_q     <= 1'b0;
            tmo_q      <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            seg_s1_q   <= i_segments[6:0];
            seg_s2_q   <= seg_s1_q;
            prev_seg_q <= seg_s2_q;
            dig_s1_q   <= i_digits;
            dig_s2_q   <= dig_s1_q;
            prev_dig_q <= dig_s2_q;
            settle_q   <= settle_d;
            took_q     <= took_d;
            bitmap_q   <= bitmap_d;
            shadow_q   <= shadow_d;
            ferr_q     <= ferr_d;
            tmo_q      <= tmo_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
            stale_q    <= stale_d;
        end
    end

    assign o_count   = count_q;
    assign o_valid   = valid_q;
    assign o_err     = err_q;
    assign o_overrun = overrun_q;
    assign o_stale   = stale_q;

endmodule

// File: tb/tb_rtc_segscan_decoder.sv
// Directed bench for rtc_segscan_decoder: scans 7-segment frames
// into the decoder and checks decoded frames and status flags.
module tb_rtc_segscan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 200;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_segments;
    logic [7:0]  i_digits;
    logic [23:0] o_count;
    logic        o_valid;
    logic        i_ready;
    logic        o_err;
    logic        o_overrun;
    logic        o_stale;

    int          total;
    int          passed;
    int          acc_n;
    int          ovr_n;
    logic [23:0] acc_count;
    logic        acc_err;

    rtc_segscan_decoder #(
        .SETTLE_CYC(SETTLE),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .i_sclk(clk),
        .i_reset_n(rst_n),
        .i_segments(i_segments),
        .i_digits(i_digits),
        .o_count(o_count),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_err(o_err),
        .o_overrun(o_overrun),
        .o_stale(o_stale)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            acc_n     = acc_n + 1;
            acc_count = o_count;
            acc_err   = o_err;
        end
        if (rst_n && o_overrun) ovr_n = ovr_n + 1;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int k, input logic [6:0] pat, input int n);
        logic [7:0] one;
        one = 8'h01 << k;
        i_digits   = ~one;
        i_segments = {1'b1, pat};
        cyc(n);
    endtask

    task automatic idle(input int n);
        i_digits   = 8'hFF;
        i_segments = 8'hFF;
        cyc(n);
    endtask

    task automatic scan(input logic [23:0] val);
        for (int k = 0; k < 6; k++) show(k, seg_of(val[4*k +: 4]), 10);
    endtask

    initial begin
        total = 0;
        passed = 0;
        acc_n = 0;
        ovr_n = 0;
        acc_count = '0;
        acc_err = 1'b0;
        rst_n = 1'b0;
        i_ready = 1'b1;
        i_digits = 8'hFF;
        i_segments = 8'hFF;
        cyc(3);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_count", {8'd0, o_count}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
        chk("rst_stale", {31'd0, o_stale}, 32'd0);
        rst_n = 1'b1;
        cyc(3);

        scan(24'h654321);
        idle(4);
        chk("f1_n", acc_n, 1);
        chk("f1_count", {8'd0, acc_count}, 32'h654321);
        chk("f1_err", {31'd0, acc_err}, 32'd0);

        show(0, seg_of(4'd9), 10);
        show(1, seg_of(4'd8), 10);
        show(2, seg_of(4'd1), SETTLE - 1);
        show(2, seg_of(4'd7), 10);
        show(3, seg_of(4'd0), 10);
        show(4, seg_of(4'd1), 10);
        show(5, seg_of(4'd2), 10);
        idle(4);
        chk("glitch_n", acc_n, 2);
        chk("glitch_count", {8'd0, acc_count}, 32'h210789);
        chk("glitch_err", {31'd0, acc_err}, 32'd0);

        scan(24'h12F456);
        idle(4);
        chk("blank_n", acc_n, 3);
        chk("blank_count", {8'd0, acc_count}, 32'h12F456);
        chk("blank_err", {31'd0, acc_err}, 32'd1);

        i_ready = 1'b0;
        scan(24'h314159);
        idle(4);
        chk("hold_valid", {31'd0, o_valid}, 32'd1);
        chk("hold_count", {8'd0, o_count}, 32'h314159);
        chk("hold_err", {31'd0, o_err}, 32'd0);
        scan(24'h265358);
        idle(4);
        chk("ovr_n", ovr_n, 1);
        chk("ovr_count", {8'd0, o_count}, 32'h314159);
        chk("ovr_valid", {31'd0, o_valid}, 32'd1);
        i_ready = 1'b1;
        cyc(1);
        chk("acc_n", acc_n, 4);
        chk("acc_count", {8'd0, acc_count}, 32'h314159);
        chk("acc_valid_fall", {31'd0, o_valid}, 32'd0);
        cyc(3);
        chk("ovr_once", ovr_n, 1);

        show(0, seg_of(4'd7), 10);
        show(1, seg_of(4'd7), 10);
        show(2, seg_of(4'd7), 10);
        idle(TIMEOUT + 30);
        chk("tmo_stale", {31'd0, o_stale}, 32'd1);
        i_digits = 8'hFA;
        i_segments = {1'b1, seg_of(4'd3)};
        cyc(20);
        chk("two_low_stale", {31'd0, o_stale}, 32'd1);
        show(3, seg_of(4'd4), 10);
        show(4, seg_of(4'd5), 10);
        show(5, seg_of(4'd6), 10);
        idle(4);
        chk("cap_clears_stale", {31'd0, o_stale}, 32'd0);
        chk("tmo_no_frame", {31'd0, o_valid}, 32'd0);
        chk("tmo_n", acc_n, 4);
        show(0, seg_of(4'd1), 10);
        show(1, seg_of(4'd2), 10);
        show(2, seg_of(4'd3), 10);
        idle(4);
        chk("tmo_frame_n", acc_n, 5);
        chk("tmo_frame", {8'd0, acc_count}, 32'h654321);

        i_ready = 1'b0;
        scan(24'h999999);
        idle(4);
        chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        show(0, seg_of(4'd5), 10);
        show(1, seg_of(4'd5), 10);
        show(2, seg_of(4'd5), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_count", {8'd0, o_count}, 32'd0);
        chk("mid_rst_err", {31'd0, o_err}, 32'd0);
        chk("mid_rst_stale", {31'd0, o_stale}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        i_ready = 1'b1;
        cyc(2);
        scan(24'h123456);
        idle(4);
        chk("post_rst_n", acc_n, 6);
        chk("post_rst_count", {8'd0, acc_count}, 32'h123456);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
